// File: rtl/collect_data_5.sv
// Collects packets from five routers into an arrival FIFO and shows the head
// entry (router number and 6-bit data) on three active-low 7-segment digits.
module collect_data_5 #(
  parameter int N2    = 7,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N2-1:0] in_router1,
  input  logic [N2-1:0] in_router2,
  input  logic [N2-1:0] in_router3,
  input  logic [N2-1:0] in_router4,
  input  logic [N2-1:0] in_router5,
  input  logic          sw_clear,
  input  logic          key_next,
  output logic [6:0]    hex_data_lo,
  output logic [6:0]    hex_data_hi,
  output logic [6:0]    hex_router,
  output logic [7:0]    pkt_count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          overflow
);

  localparam int DW = N2 - 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 3;
  localparam logic [6:0] DASH = 7'b1111110;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    return ~p;
  endfunction

  logic [4:0]    rin_valid;
  logic [DW-1:0] rin_data [5];

  assign rin_valid   = {in_router5[N2-1], in_router4[N2-1], in_router3[N2-1],
                        in_router2[N2-1], in_router1[N2-1]};
  assign rin_data[0] = in_router1[DW-1:0];
  assign rin_data[1] = in_router2[DW-1:0];
  assign rin_data[2] = in_router3[DW-1:0];
  assign rin_data[3] = in_router4[DW-1:0];
  assign rin_data[4] = in_router5[DW-1:0];

  logic [4:0]    prev_valid_q, pending_q, pending_d;
  logic [DW-1:0] pend_data_q [5];
  logic [DW-1:0] pend_data_d [5];
  logic          key_q;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    pkt_count_d;
  logic          overflow_d;

  logic [4:0]    arrival;
  logic          pop, push, have_pend;
  logic [2:0]    sel_idx;
  logic [EW-1:0] wr_entry, head;
  logic [5:0]    head_data;
  logic [2:0]    head_rtr;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    arrival   = rin_valid & ~prev_valid_q & {5{~sw_clear}};
    pop       = key_next && !key_q && (count_q != '0) && !sw_clear;
    have_pend = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending_q[i]) begin
        have_pend = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    // A pop in the same cycle frees the slot the write needs when full.
    push     = have_pend && ((count_q != CW'(DEPTH)) || pop) && !sw_clear;
    wr_entry = {sel_idx + 3'd1, pend_data_q[sel_idx]};

    overflow_d = overflow;
    for (int i = 0; i < 5; i++) begin
      pending_d[i]   = pending_q[i];
      pend_data_d[i] = pend_data_q[i];
      if (push && sel_idx == 3'(i)) pending_d[i] = 1'b0;
      if (arrival[i]) begin
        if (pending_q[i] && !(push && sel_idx == 3'(i))) begin
          overflow_d = 1'b1;
        end else begin
          pending_d[i]   = 1'b1;
          pend_data_d[i] = rin_data[i];
        end
      end
    end

    wptr_d      = wptr_q + AW'(push);
    rptr_d      = rptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    pkt_count_d = (push && pkt_count != 8'hFF) ? pkt_count + 8'd1 : pkt_count;

    if (sw_clear) begin
      pending_d   = '0;
      overflow_d  = 1'b0;
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      pkt_count_d = '0;
    end
  end

  assign head      = mem[rptr_q];
  assign head_rtr  = head[EW-1 -: 3];
  assign head_data = 6'(head[DW-1:0]);

  // NOTE: the storage array has no reset; the pointers and occupancy define
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_valid_q <= '0;
      pending_q    <= '0;
      pend_data_q  <= '{default: '0};
      key_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      pkt_count    <= '0;
      overflow     <= 1'b0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      hex_data_lo  <= DASH;
      hex_data_hi  <= DASH;
      hex_router   <= DASH;
    end else begin
      prev_valid_q <= rin_valid;
      pending_q    <= pending_d;
      pend_data_q  <= pend_data_d;
      key_q        <= key_next;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      pkt_count    <= pkt_count_d;
      overflow     <= overflow_d;
      fifo_empty   <= (count_d == '0);
      fifo_full    <= (count_d == CW'(DEPTH));
      if (count_q == '0) begin
        hex_data_lo <= DASH;
        hex_data_hi <= DASH;
        hex_router  <= DASH;
      end else begin
        hex_data_lo <= seg7(head_data[3:0]);
        hex_data_hi <= seg7({2'b00, head_data[5:4]});
        hex_router  <= seg7({1'b0, head_rtr});
      end
    end
  end

endmodule

// File: tb/tb_collect_data_5.sv
// Directed self-checking bench for collect_data_5: one task per scenario,
// hand-computed expected display codes and counters.
module tb_collect_data_5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] in_r [1:5];
  logic       sw_clear, key_next;
  logic [6:0] hex_data_lo, hex_data_hi, hex_router;
  logic [7:0] pkt_count;
  logic       fifo_empty, fifo_full, overflow;

  int checks   = 0;
  int failures = 0;

  localparam logic [20:0] DASH3 = {3{7'b1111110}};

  collect_data_5 dut (
    .clk(clk), .rst_n(rst_n),
    .in_router1(in_r[1]), .in_router2(in_r[2]), .in_router3(in_r[3]),
    .in_router4(in_r[4]), .in_router5(in_r[5]),
    .sw_clear(sw_clear), .key_next(key_next),
    .hex_data_lo(hex_data_lo), .hex_data_hi(hex_data_hi), .hex_router(hex_router),
    .pkt_count(pkt_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Active-low abcdefg codes, already inverted by hand.
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [20:0] exp_disp(input int r, input logic [5:0] d);
    return {seg(4'(r)), seg({2'b00, d[5:4]}), seg(d[3:0])};
  endfunction

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    key_next = 1'b1;
    cycle(1);
    key_next = 1'b0;
    cycle(1);
  endtask

  task automatic pulse(input int r, input logic [5:0] d);
    in_r[r] = {1'b1, d};
    cycle(1);
    in_r[r] = 7'd0;
    cycle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_clear = 1'b0; key_next = 1'b0;
    for (int i = 1; i <= 5; i++) in_r[i] = 7'd0;
    cycle(2);
    checks++;
    if ({fifo_empty, fifo_full, overflow} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=100", {fifo_empty, fifo_full, overflow});
    end
    checks++;
    if (pkt_count !== 8'd0) begin
      failures++; $display("FAIL reset_pkt got=%0d exp=0", pkt_count);
    end
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== DASH3) begin
      failures++; $display("FAIL reset_hex got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, DASH3);
    end
    rst_n = 1'b1;
    cycle(1);
  endtask

  task automatic test_single();
    in_r[3] = 7'b1_000101;
    cycle(1);
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++; $display("FAIL single_e0_empty got=%b exp=1", fifo_empty);
    end
    cycle(1);
    checks++;
    if ({fifo_empty, pkt_count} !== {1'b0, 8'd1}) begin
      failures++; $display("FAIL single_e1 got=%b/%0d exp=0/1", fifo_empty, pkt_count);
    end
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== DASH3) begin
      failures++; $display("FAIL single_e1_hex got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, DASH3);
    end
    cycle(1);
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== exp_disp(3, 6'h05)) begin
      failures++; $display("FAIL single_e2_hex got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, exp_disp(3, 6'h05));
    end
    in_r[3] = 7'd0;
    press();
    checks++;
    if ({fifo_empty, hex_router, hex_data_hi, hex_data_lo} !== {1'b1, DASH3}) begin
      failures++; $display("FAIL single_pop got=%b/%h exp=1/%h", fifo_empty, {hex_router, hex_data_hi, hex_data_lo}, DASH3);
    end
  endtask

  task automatic test_simultaneous();
    in_r[2] = {1'b1, 6'h12};
    in_r[4] = {1'b1, 6'h3F};
    in_r[5] = {1'b1, 6'h07};
    cycle(1);
    in_r[2] = 7'd0; in_r[4] = 7'd0; in_r[5] = 7'd0;
    cycle(1);
    checks++;
    if (pkt_count !== 8'd2) begin
      failures++; $display("FAIL simul_first_write got=%0d exp=2", pkt_count);
    end
    cycle(2);
    checks++;
    if (pkt_count !== 8'd4) begin
      failures++; $display("FAIL simul_all_written got=%0d exp=4", pkt_count);
    end
    for (int k = 0; k < 4; k++) begin
      logic [20:0] e;
      case (k)
        0: e = exp_disp(2, 6'h12);
        1: e = exp_disp(4, 6'h3F);
        2: e = exp_disp(5, 6'h07);
        default: e = DASH3;
      endcase
      checks++;
      if ({hex_router, hex_data_hi, hex_data_lo} !== e) begin
        failures++; $display("FAIL simul_order[%0d] got=%h exp=%h", k, {hex_router, hex_data_hi, hex_data_lo}, e);
      end
      if (k < 3) press();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) pulse(1, 6'(8 + i));
    checks++;
    if ({fifo_full, fifo_empty, pkt_count} !== {2'b10, 8'd12}) begin
      failures++; $display("FAIL bp_full got=%b%b/%0d exp=10/12", fifo_full, fifo_empty, pkt_count);
    end
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== exp_disp(1, 6'h08)) begin
      failures++; $display("FAIL bp_head got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, exp_disp(1, 6'h08));
    end
    pulse(2, 6'h30);
    cycle(2);
    checks++;
    if ({fifo_full, pkt_count} !== {1'b1, 8'd12}) begin
      failures++; $display("FAIL bp_blocked got=%b/%0d exp=1/12", fifo_full, pkt_count);
    end
    key_next = 1'b1;
    cycle(1);
    checks++;
    if ({fifo_full, pkt_count} !== {1'b1, 8'd13}) begin
      failures++; $display("FAIL bp_pop_push got=%b/%0d exp=1/13", fifo_full, pkt_count);
    end
    key_next = 1'b0;
    cycle(1);
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== exp_disp(1, 6'h09)) begin
      failures++; $display("FAIL bp_new_head got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, exp_disp(1, 6'h09));
    end
  endtask

  task automatic test_overflow();
    pulse(1, 6'h21);
    pulse(1, 6'h22);
    checks++;
    if ({overflow, pkt_count} !== {1'b1, 8'd13}) begin
      failures++; $display("FAIL ovf_flag got=%b/%0d exp=1/13", overflow, pkt_count);
    end
    for (int k = 0; k < 9; k++) begin
      logic [20:0] e;
      press();
      if (k < 6)       e = exp_disp(1, 6'(10 + k));
      else if (k == 6) e = exp_disp(2, 6'h30);
      else if (k == 7) e = exp_disp(1, 6'h21);
      else             e = DASH3;
      checks++;
      if ({hex_router, hex_data_hi, hex_data_lo} !== e) begin
        failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", k, {hex_router, hex_data_hi, hex_data_lo}, e);
      end
    end
    checks++;
    if ({fifo_empty, overflow, pkt_count} !== {2'b11, 8'd14}) begin
      failures++; $display("FAIL ovf_end got=%b%b/%0d exp=11/14", fifo_empty, overflow, pkt_count);
    end
  endtask

  task automatic test_wraparound();
    sw_clear = 1'b1;
    cycle(1);
    sw_clear = 1'b0;
    checks++;
    if ({overflow, pkt_count} !== {1'b0, 8'd0}) begin
      failures++; $display("FAIL wrap_clear got=%b/%0d exp=0/0", overflow, pkt_count);
    end
    pulse(1, 6'd3);
    for (int i = 1; i < 20; i++) begin
      int r;
      logic [5:0] d;
      r = (i % 5) + 1;
      d = 6'(i * 7 + 3);
      in_r[r] = {1'b1, d};
      cycle(1);
      in_r[r] = 7'd0;
      key_next = 1'b1;
      cycle(1);
      key_next = 1'b0;
      cycle(1);
      checks++;
      if ({fifo_empty, fifo_full, hex_router, hex_data_hi, hex_data_lo} !== {2'b00, exp_disp(r, d)}) begin
        failures++;
        $display("FAIL wrap[%0d] got=%b%b/%h exp=00/%h", i, fifo_empty, fifo_full,
                 {hex_router, hex_data_hi, hex_data_lo}, exp_disp(r, d));
      end
    end
    checks++;
    if (pkt_count !== 8'd20) begin
      failures++; $display("FAIL wrap_pkt got=%0d exp=20", pkt_count);
    end
    press();
  endtask

  task automatic test_clear();
    in_r[1] = {1'b1, 6'h01};
    in_r[2] = {1'b1, 6'h02};
    in_r[3] = {1'b1, 6'h03};
    cycle(4);
    checks++;
    if (pkt_count !== 8'd23) begin
      failures++; $display("FAIL clr_fill got=%0d exp=23", pkt_count);
    end
    sw_clear = 1'b1;
    cycle(1);
    checks++;
    if ({fifo_empty, pkt_count} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL clr_state got=%b/%0d exp=1/0", fifo_empty, pkt_count);
    end
    cycle(1);
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== DASH3) begin
      failures++; $display("FAIL clr_hex got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, DASH3);
    end
    sw_clear = 1'b0;
    cycle(3);
    checks++;
    if ({fifo_empty, pkt_count} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL clr_held_valid got=%b/%0d exp=1/0", fifo_empty, pkt_count);
    end
    in_r[1] = 7'd0; in_r[2] = 7'd0; in_r[3] = 7'd0;
    press();
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++; $display("FAIL clr_empty_press got=%b exp=1", fifo_empty);
    end
    pulse(5, 6'h2C);
    cycle(1);
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== exp_disp(5, 6'h2C)) begin
      failures++; $display("FAIL clr_press_consumed got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, exp_disp(5, 6'h2C));
    end
  endtask

  task automatic test_reset_mid();
    pulse(1, 6'h11);
    in_r[2] = {1'b1, 6'h22};
    in_r[4] = {1'b1, 6'h1E};
    cycle(1);
    rst_n = 1'b0;
    in_r[2] = 7'd0;
    cycle(1);
    checks++;
    if ({fifo_empty, fifo_full, overflow, pkt_count, hex_router, hex_data_hi, hex_data_lo} !==
        {3'b100, 8'd0, DASH3}) begin
      failures++;
      $display("FAIL rstmid_values got=%b%b%b/%0d/%h exp=100/0/%h", fifo_empty, fifo_full, overflow,
               pkt_count, {hex_router, hex_data_hi, hex_data_lo}, DASH3);
    end
    rst_n = 1'b1;
    cycle(1);
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++; $display("FAIL rstmid_pending_dropped got=%b exp=1", fifo_empty);
    end
    cycle(1);
    checks++;
    if ({fifo_empty, pkt_count} !== {1'b0, 8'd1}) begin
      failures++; $display("FAIL rstmid_release_arrival got=%b/%0d exp=0/1", fifo_empty, pkt_count);
    end
    cycle(1);
    checks++;
    if ({hex_router, hex_data_hi, hex_data_lo} !== exp_disp(4, 6'h1E)) begin
      failures++; $display("FAIL rstmid_hex got=%h exp=%h", {hex_router, hex_data_hi, hex_data_lo}, exp_disp(4, 6'h1E));
    end
    in_r[4] = 7'd0;
    press();
    checks++;
    if ({fifo_empty, hex_router, hex_data_hi, hex_data_lo} !== {1'b1, DASH3}) begin
      failures++; $display("FAIL rstmid_drain got=%b/%h exp=1/%h", fifo_empty, {hex_router, hex_data_hi, hex_data_lo}, DASH3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_wraparound();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
